// File: rtl/outmem_reader.sv
// outmem_reader: drains the T x M result matrix from the output SRAM and streams it
// row-major on a valid/ready port. Define OUTMEM_ZERO_CHECK_EN for the sticky zero check on ERR.
module outmem_reader #(
  parameter int EW        = 16,
  parameter int DW        = 64,
  parameter int AW        = 4,
  parameter int ROWSTRIDE = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [11:0]   MNT,
  output logic          BUSY,
  output logic          DONE,
  output logic          EN_O,
  output logic          RW_O,
  output logic [AW-1:0] ADDR_O,
  input  logic [DW-1:0] RDATA_O,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [EW-1:0] OUT_DATA,
  output logic [2:0]    OUT_ROW,
  output logic [2:0]    OUT_COL,
  output logic          OUT_LAST,
  output logic          ERR
);
  localparam int LN = DW / EW;
  localparam int LW = (LN > 1) ? $clog2(LN) : 1;

  typedef enum logic [2:0] {IDLE, RD, CAP, EMIT, FIN} state_t;

  state_t        state_reg;
  logic [3:0]    m_reg, t_reg;
  logic [2:0]    r_reg, g_reg;
  logic [LW-1:0] lane_reg;
  logic [DW-1:0] buf_reg;
  logic          busy_reg, done_reg, en_reg, valid_reg, last_reg;
  logic [AW-1:0] addr_reg;
  logic [EW-1:0] data_reg;
  logic [2:0]    row_reg, col_reg;

  // Oversized dimensions are clamped to the 8x8 array.
  logic [3:0] m_in, t_in;
  assign m_in = (MNT[11:8] > 4'd8) ? 4'd8 : MNT[11:8];
  assign t_in = (MNT[3:0]  > 4'd8) ? 4'd8 : MNT[3:0];

  logic [EW-1:0] buf_lanes [LN];
`ifdef OUTMEM_ZERO_CHECK_EN
  logic [LN-1:0] lane_bad;
`endif
  logic [7:0] grp_base, col_cur, m_last;

  for (genvar gi = 0; gi < LN; gi++) begin : g_lane
    assign buf_lanes[gi] = buf_reg[DW-1-gi*EW -: EW];
`ifdef OUTMEM_ZERO_CHECK_EN
    assign lane_bad[gi] = ((grp_base + 8'(gi)) >= 8'(m_reg)) &&
                          (|RDATA_O[DW-1-gi*EW -: EW]);
`endif
  end

  logic [LW-1:0] lane_nxt;
  logic          row_last, end_word, last_elem, more_grp;
  assign grp_base  = 8'(g_reg) * 8'(LN);
  assign col_cur   = grp_base + 8'(lane_reg);
  assign m_last    = 8'(m_reg) - 8'd1;
  assign lane_nxt  = lane_reg + LW'(1);
  assign row_last  = ({1'b0, r_reg} == (t_reg - 4'd1));
  assign end_word  = (lane_reg == LW'(LN-1)) || (col_cur == m_last);
  assign last_elem = row_last && (col_cur == m_last);
  assign more_grp  = (grp_base + 8'(LN)) < 8'(m_reg);

  logic extra_needed, extra_mode;
`ifdef OUTMEM_ZERO_CHECK_EN
  logic extra_reg, err_reg;
  assign extra_needed = (t_reg != 4'd8);
  assign extra_mode   = extra_reg;
`else
  assign extra_needed = 1'b0;
  assign extra_mode   = 1'b0;
`endif

  function automatic logic [AW-1:0] word_addr(input logic [2:0] g, input logic [2:0] r);
    logic [31:0] a;
    a = 32'(g) * 32'(ROWSTRIDE) + 32'(r);
    return a[AW-1:0];
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      t_reg     <= '0;
      r_reg     <= '0;
      g_reg     <= '0;
      lane_reg  <= '0;
      buf_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      en_reg    <= 1'b0;
      addr_reg  <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      last_reg  <= 1'b0;
`ifdef OUTMEM_ZERO_CHECK_EN
      extra_reg <= 1'b0;
      err_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      en_reg   <= 1'b0;
      addr_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (START) begin
`ifdef OUTMEM_ZERO_CHECK_EN
            err_reg <= 1'b0;
`endif
            if (m_in != 4'd0 && t_in != 4'd0) begin
              m_reg     <= m_in;
              t_reg     <= t_in;
              r_reg     <= '0;
              g_reg     <= '0;
              lane_reg  <= '0;
              busy_reg  <= 1'b1;
              en_reg    <= 1'b1;
              addr_reg  <= word_addr(3'd0, 3'd0);
              state_reg <= RD;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= FIN;
            end
          end
        end
        RD: state_reg <= CAP;
        CAP: begin
          if (extra_mode) begin
`ifdef OUTMEM_ZERO_CHECK_EN
            // Trailing rows T..7 are only inspected, never streamed.
            if (|RDATA_O) err_reg <= 1'b1;
            if (r_reg == 3'd7) begin
              if (more_grp) begin
                g_reg     <= g_reg + 3'd1;
                r_reg     <= t_reg[2:0];
                en_reg    <= 1'b1;
                addr_reg  <= word_addr(g_reg + 3'd1, t_reg[2:0]);
                state_reg <= RD;
              end else begin
                extra_reg <= 1'b0;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= FIN;
              end
            end else begin
              r_reg     <= r_reg + 3'd1;
              en_reg    <= 1'b1;
              addr_reg  <= word_addr(g_reg, r_reg + 3'd1);
              state_reg <= RD;
            end
`endif
          end else begin
`ifdef OUTMEM_ZERO_CHECK_EN
            if (|lane_bad) err_reg <= 1'b1;
`endif
            buf_reg   <= RDATA_O;
            lane_reg  <= '0;
            valid_reg <= 1'b1;
            data_reg  <= RDATA_O[DW-1 -: EW];
            row_reg   <= r_reg;
            col_reg   <= grp_base[2:0];
            last_reg  <= row_last && (grp_base == m_last);
            state_reg <= EMIT;
          end
        end
        EMIT: begin
          if (valid_reg && OUT_READY) begin
            if (!end_word) begin
              lane_reg <= lane_nxt;
              data_reg <= buf_lanes[lane_nxt];
              col_reg  <= col_cur[2:0] + 3'd1;
              last_reg <= row_last && ((col_cur + 8'd1) == m_last);
            end else begin
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
              if (last_elem && extra_needed) begin
`ifdef OUTMEM_ZERO_CHECK_EN
                extra_reg <= 1'b1;
                g_reg     <= '0;
                r_reg     <= t_reg[2:0];
                en_reg    <= 1'b1;
                addr_reg  <= word_addr(3'd0, t_reg[2:0]);
                state_reg <= RD;
`endif
              end else if (last_elem) begin
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                state_reg <= FIN;
              end else begin
                // Next column group of this row, else first group of the next row.
                if (more_grp) begin
                  g_reg    <= g_reg + 3'd1;
                  addr_reg <= word_addr(g_reg + 3'd1, r_reg);
                end else begin
                  g_reg    <= '0;
                  r_reg    <= r_reg + 3'd1;
                  addr_reg <= word_addr(3'd0, r_reg + 3'd1);
                end
                en_reg    <= 1'b1;
                state_reg <= RD;
              end
            end
          end
        end
        FIN:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign EN_O      = en_reg;
  assign RW_O      = 1'b0;
  assign ADDR_O    = addr_reg;
  assign OUT_VALID = valid_reg;
  assign OUT_DATA  = data_reg;
  assign OUT_ROW   = row_reg;
  assign OUT_COL   = col_reg;
  assign OUT_LAST  = last_reg;
`ifdef OUTMEM_ZERO_CHECK_EN
  assign ERR = err_reg;
`else
  assign ERR = 1'b0;
`endif
endmodule

// File: tb/tb_outmem_reader.sv
// Bench for outmem_reader: SRAM model, scoreboard of expected elements and read addresses,
// ready patterns (always / 1,0,0,1 / random), reset mid-drain and the zero-size START.
module tb_outmem_reader;
  logic        CLK = 1'b0;
  logic        RST, START, OUT_READY;
  logic [11:0] MNT;
  logic        BUSY, DONE, EN_O, RW_O, OUT_VALID, OUT_LAST, ERR;
  logic [3:0]  ADDR_O;
  logic [63:0] rdata;
  logic [15:0] OUT_DATA;
  logic [2:0]  OUT_ROW, OUT_COL;

  always #5 CLK = ~CLK;

  outmem_reader dut (
    .CLK(CLK), .RST(RST), .START(START), .MNT(MNT), .BUSY(BUSY), .DONE(DONE),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .RDATA_O(rdata),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_ROW(OUT_ROW), .OUT_COL(OUT_COL), .OUT_LAST(OUT_LAST), .ERR(ERR)
  );

  logic [63:0] mem [16];
  always @(posedge CLK) if (EN_O) rdata <= mem[ADDR_O];

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last;
  } elem_t;

  elem_t      elem_q[$];
  logic [3:0] addr_q[$];
  int         n_cmp = 0, n_bad = 0;
  int         hs_cnt = 0, done_cnt = 0;
  logic       err_exp = 1'b0;
  logic       hold_pending = 1'b0;
  int         ready_mode = 0;
  logic [3:0] ready_pat = 4'b1001;
  bit         chk_err_early = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_of(input logic [63:0] w, input int l);
    return w[63-16*l -: 16];
  endfunction

  // Reference model: fills the element and read-address scoreboards for one drain.
  function automatic void build_expect(input logic [11:0] mnt);
    int m, t, ng;
    elem_t e;
    m = int'(mnt[11:8]); if (m > 8) m = 8;
    t = int'(mnt[3:0]);  if (t > 8) t = 8;
    err_exp = 1'b0;
    elem_q.delete();
    addr_q.delete();
    if (m == 0 || t == 0) return;
    ng = (m + 3) / 4;
    for (int r = 0; r < t; r++)
      for (int c = 0; c < m; c++) begin
        e.data = lane_of(mem[(c/4)*8 + r], c % 4);
        e.row  = 3'(r);
        e.col  = 3'(c);
        e.last = (r == t-1) && (c == m-1);
        elem_q.push_back(e);
      end
    for (int r = 0; r < t; r++)
      for (int g = 0; g < ng; g++) begin
        addr_q.push_back(4'(g*8 + r));
`ifdef OUTMEM_ZERO_CHECK_EN
        for (int l = 0; l < 4; l++)
          if (g*4 + l >= m && lane_of(mem[g*8 + r], l) != 16'h0) err_exp = 1'b1;
`endif
      end
`ifdef OUTMEM_ZERO_CHECK_EN
    for (int g = 0; g < ng; g++)
      for (int r = t; r < 8; r++) begin
        addr_q.push_back(4'(g*8 + r));
        if (mem[g*8 + r] != 64'h0) err_exp = 1'b1;
      end
`endif
  endfunction

  // Monitor: every read and every presented element is compared against the scoreboards.
  always @(negedge CLK) begin
    if (RST) begin
      hold_pending <= 1'b0;
    end else begin
      if (EN_O) begin
        check_val("rw_o", 32'(RW_O), 32'd0);
        if (addr_q.size() == 0) check_val("en_o_unexpected", 32'(EN_O), 32'd0);
        else                    check_val("addr_o", 32'(ADDR_O), 32'(addr_q.pop_front()));
      end
      if (hold_pending) check_val("valid_held", 32'(OUT_VALID), 32'd1);
      if (OUT_VALID) begin
        if (elem_q.size() == 0) begin
          check_val("valid_unexpected", 32'(OUT_VALID), 32'd0);
        end else begin
          check_val("out_data", 32'(OUT_DATA), 32'(elem_q[0].data));
          check_val("out_row",  32'(OUT_ROW),  32'(elem_q[0].row));
          check_val("out_col",  32'(OUT_COL),  32'(elem_q[0].col));
          check_val("out_last", 32'(OUT_LAST), 32'(elem_q[0].last));
          if (OUT_READY) begin
            void'(elem_q.pop_front());
            hs_cnt <= hs_cnt + 1;
          end
        end
      end
      hold_pending <= OUT_VALID && !OUT_READY;
      if (DONE) done_cnt <= done_cnt + 1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    OUT_READY = 1'b1;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      case (ready_mode)
        1:       OUT_READY = ready_pat[cyc % 4];
        2:       OUT_READY = 1'($urandom_range(0, 1));
        default: OUT_READY = 1'b1;
      endcase
    end
  end

  task automatic start_drain(input logic [11:0] mnt);
    @(posedge CLK); #1;
    MNT   = mnt;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic run_drain(input logic [11:0] mnt, input int mode);
    int lat, hs0, d0, n_exp;
    bit got;
    ready_mode = mode;
    build_expect(mnt);
    hs0   = hs_cnt;
    d0    = done_cnt;
    n_exp = elem_q.size();
    start_drain(mnt);
    if (n_exp == 0) begin
      @(negedge CLK);
      check_val("zero_done", 32'(DONE), 32'd1);
      check_val("zero_busy", 32'(BUSY), 32'd0);
    end else begin
      for (lat = 1; lat <= 10; lat++) begin
        @(negedge CLK);
        if (lat == 1) check_val("busy_rd", 32'(BUSY), 32'd1);
        if (OUT_VALID) break;
        @(posedge CLK);
      end
      check_val("first_valid_lat", 32'(lat), 32'd3);
      if (chk_err_early) check_val("err_after_cap", 32'(ERR), 32'd1);
      got = 1'b0;
      for (int i = 0; i < 800; i++) begin
        @(negedge CLK);
        if (DONE) begin
          got = 1'b1;
          break;
        end
      end
      check_val("done_seen", 32'(got), 32'd1);
    end
    @(negedge CLK);
    check_val("done_width", 32'(DONE), 32'd0);
    check_val("busy_after", 32'(BUSY), 32'd0);
    check_val("done_count", 32'(done_cnt - d0), 32'd1);
    check_val("handshakes", 32'(hs_cnt - hs0), 32'(n_exp));
    check_val("elems_left", 32'(elem_q.size()), 32'd0);
    check_val("reads_left", 32'(addr_q.size()), 32'd0);
    check_val("err", 32'(ERR), 32'(err_exp));
    $display("drain MNT=%03h ready_mode=%0d elements=%0d err=%0b", mnt, mode, hs_cnt - hs0, ERR);
  endtask

  initial begin
    bit got;
    int hs0;
    RST   = 1'b1;
    START = 1'b0;
    MNT   = '0;
    for (int a = 0; a < 16; a++)
      mem[a] = {16'(a+1), 16'(a+2), 16'(a+3), 16'(a+4)};
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_busy",  32'(BUSY),      32'd0);
    check_val("rst_done",  32'(DONE),      32'd0);
    check_val("rst_en",    32'(EN_O),      32'd0);
    check_val("rst_addr",  32'(ADDR_O),    32'd0);
    check_val("rst_valid", 32'(OUT_VALID), 32'd0);
    check_val("rst_err",   32'(ERR),       32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    run_drain(12'h444, 0);
    run_drain(12'h838, 0);
    run_drain(12'h521, 0);
    run_drain(12'h444, 1);
    run_drain(12'h044, 0);

    // Reset in the middle of a drain, then a clean restart from address 0.
    ready_mode = 0;
    build_expect(12'h444);
    hs0 = hs_cnt;
    start_drain(12'h444);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (OUT_VALID && (hs_cnt - hs0) >= 5) begin
        got = 1'b1;
        break;
      end
    end
    check_val("reset_window", 32'(got), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    elem_q.delete();
    addr_q.delete();
    @(negedge CLK);
    check_val("rst_mid_valid", 32'(OUT_VALID), 32'd0);
    check_val("rst_mid_busy",  32'(BUSY),      32'd0);
    check_val("rst_mid_en",    32'(EN_O),      32'd0);
    $display("reset asserted mid-drain after %0d handshakes", hs_cnt - hs0);
    repeat (6) @(negedge CLK);
    run_drain(12'h444, 0);

    for (int a = 0; a < 16; a++) mem[a] = {$urandom, $urandom};
    run_drain(12'h9F9, 2);
    run_drain(12'h736, 2);

`ifdef OUTMEM_ZERO_CHECK_EN
    for (int a = 0; a < 16; a++) mem[a] = 64'h0;
    mem[0] = {16'h0011, 16'h0012, 16'h0001, 16'h0000};
    mem[1] = {16'h0021, 16'h0022, 16'h0000, 16'h0000};
    chk_err_early = 1'b1;
    run_drain(12'h222, 0);
    chk_err_early = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/outmem_reader.md
Name: outmem_reader

Overview:
- Drains the 64-bit output SRAM after macarray has written the T x M result matrix.
- Reads each SRAM word and unpacks it into 16-bit elements, then streams them in row-major order on a valid/ready interface for checking and host readback.
- Sits on the OUT_MEM port opposite macarray's write side. Only one of the two may drive the SRAM at a time; the top level arbitrates with START sequencing.

Parameters:
- EW, 16, element width in bits; must divide DW.
- DW, 64, SRAM word width; lanes per word LN = DW/EW = 4.
- AW, 4, SRAM address width.
- ROWSTRIDE, 8, address offset between column groups.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  one-cycle pulse; begins a drain when idle.
- MNT  in  12  [11:8]=M, [7:4]=N (ignored), [3:0]=T; sampled on accepted START.
- BUSY  out  1  high from cycle after accepted START until DONE.
- DONE  out  1  one-cycle pulse after the last element handshake.
- EN_O  out  1  SRAM chip enable.
- RW_O  out  1  SRAM write strobe; tied 0 (read only).
- ADDR_O  out  AW  SRAM address.
- RDATA_O  in  DW  SRAM read data; valid the cycle after an EN_O cycle.
- OUT_VALID  out  1  element valid.
- OUT_READY  in  1  consumer ready.
- OUT_DATA  out  EW  element value, two's complement, passed unmodified.
- OUT_ROW  out  3  row index r, 0-based.
- OUT_COL  out  3  column index c, 0-based.
- OUT_LAST  out  1  high with element (T-1, M-1).
- ERR  out  1  sticky zero-check error (see Optional Feature).

Behaviour:
- Reset (RST high at a clock edge): state IDLE; all outputs 0; counters and word buffer cleared. Takes effect mid-drain; no further SRAM access after that edge.
- Memory map: element (r,c) is at address (c/4)*ROWSTRIDE + r, lane c%4. Lane 0 = bits [63:48], lane 3 = bits [15:0].
- States:
  - IDLE: START=1 and M≠0 and T≠0 -> latch M,T; r=0, g=0; go to RD. START with M=0 or T=0 -> DONE pulse next cycle, no SRAM access. START while not IDLE is ignored.
  - RD (1 cycle): EN_O=1, ADDR_O=g*ROWSTRIDE+r -> CAP.
  - CAP (1 cycle): register RDATA_O into the word buffer; lane=0 -> EMIT.
  - EMIT:
    - OUT_VALID=1 with OUT_DATA = buffer lane, OUT_COL = 4g+lane, OUT_ROW = r.
    - On OUT_VALID & OUT_READY, advance lane.
    - End of word when lane reaches LN-1 or 4g+lane = M-1.
    - At end of word: g++ when 4g+4 < M, else g=0 and r++. Then go to RD, or FIN if this was element (T-1, M-1).
  - FIN: DONE=1 for one cycle, BUSY=0 -> IDLE.
- Latency: first OUT_VALID 3 cycles after the START edge (RD, CAP, EMIT). Each word costs 2 idle cycles plus its element count.
- OUT_VALID, OUT_DATA, OUT_ROW and OUT_COL stay stable while OUT_VALID=1 and OUT_READY=0. OUT_VALID never drops without a handshake.
- EN_O is asserted only in RD. ADDR_O holds 0 outside RD. RW_O is always 0.
- M or T > 8: clamp to 8.
- Lanes with column ≥ M are never emitted.

Optional Feature:
- Macro: OUTMEM_ZERO_CHECK_EN.
- Defined:
  - In CAP, any unused lane (4g+lane ≥ M) that is non-zero sets ERR. ERR is cleared only by RST or an accepted START.
  - When the last row group is reached, the reader additionally reads rows T..7 of each group in RD/CAP cycles without emitting; any non-zero word sets ERR.
  - DONE follows these extra reads.
- Undefined: ERR tied 0; no extra reads.

Test Plan:
- MNT=12'h444, OUT_READY=1, SRAM addr r holds {r+1,r+2,r+3,r+4} in 16-bit lanes -> 16 elements; (0,0)=1, (3,3)=7; OUT_LAST on (3,3); ADDR_O sequence 0,1,2,3; DONE once.
- MNT=12'h838, T=8 -> reads alternate 0,8,1,9,…,7,15; 64 elements in row-major order; OUT_COL 4..7 taken from addr 8+r.
- MNT=12'h521, M=5, T=1 -> reads addr 0 then 8; 5 elements; element (0,4) = addr 8 bits [63:48]; OUT_LAST on (0,4).
- MNT=12'h444, OUT_READY toggling 1,0,0,1 -> no element lost or duplicated; outputs held during stalls; total 16 handshakes.
- START with MNT=12'h044 -> DONE next cycle, EN_O never high. Assert RST mid-EMIT -> next cycle OUT_VALID=0, BUSY=0. A new START then restarts from addr 0.
- OUTMEM_ZERO_CHECK_EN, MNT=12'h222, addr 0 lane 2 = 16'h0001 -> ERR=1 after the addr-0 CAP cycle; elements still emitted correctly.
